// File: rtl/riscv_core_dcache_data_array.sv
// ----------------------------------------------------------------------------
// riscv_core_dcache_data_array
//
// Data store of an N-way set-associative D-cache. It holds line data only.
// Tags, valid bits and LRU state live in the dcache controller.
//
// Core port
//   Sized load, store and AMO-write accesses of 1, 2, 4 or 8 bytes.
//   Read data is registered: it appears one cycle after acceptance,
//   zero-extended and right-aligned.
//   A misaligned access is dropped without touching the array. The next cycle
//   reports it through o_misaligned, with o_rdata_valid high and o_rdata = 0.
//
// Refill port
//   Multi-beat line fill under a valid/ready handshake. Beats are placed by an
//   internal counter. i_beat_last is only cross-checked; a disagreement pulses
//   o_refill_err.
//
// Ports
//   i_clk, i_rst_n                      clock; synchronous active-low reset
//   i_req_valid / o_req_ready           core request handshake
//                                       (ready only in IDLE)
//   i_req_we, i_req_addr, i_req_way,
//   i_req_size, i_req_wdata             core access attributes
//   i_amo_wr, i_amo_result              AMO write-back data select
//                                       (word/dword only)
//   o_rdata_valid, o_rdata,
//   o_misaligned                        core response, one cycle after accept
//   i_refill_start, i_refill_index,
//   i_refill_way                        line fill request, sampled in IDLE
//   i_beat_valid / o_beat_ready,
//   i_beat_data, i_beat_last            refill beat stream
//   o_refill_done, o_refill_err         refill completion / framing error pulses
//   o_parity_err                        read parity failure
//                                       (only with RISCV_DCACHE_BYTE_PARITY_EN)
//
// Build option
//   RISCV_DCACHE_BYTE_PARITY_EN
//     Stores one even-parity bit per data byte.
//     Adds the o_parity_err output.
// ----------------------------------------------------------------------------
module riscv_core_dcache_data_array #(
   parameter int  NUM_WAYS        = 2,
   parameter int  INDEX_WIDTH     = 7,
   parameter int  LINE_BYTES      = 32,
   parameter int  ADDR_WIDTH      = 64,
   parameter int  CORE_DATA_WIDTH = 64,
   parameter int  BEAT_WIDTH      = 64,
   localparam int WAY_W           = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_req_valid,
   output logic                       o_req_ready,
   input  logic                       i_req_we,
   input  logic [ADDR_WIDTH-1:0]      i_req_addr,
   input  logic [WAY_W-1:0]           i_req_way,
   input  logic [1:0]                 i_req_size,
   input  logic [CORE_DATA_WIDTH-1:0] i_req_wdata,
   input  logic                       i_amo_wr,
   input  logic [CORE_DATA_WIDTH-1:0] i_amo_result,
   output logic                       o_rdata_valid,
   output logic [CORE_DATA_WIDTH-1:0] o_rdata,
   output logic                       o_misaligned,
   input  logic                       i_refill_start,
   input  logic [INDEX_WIDTH-1:0]     i_refill_index,
   input  logic [WAY_W-1:0]           i_refill_way,
   input  logic                       i_beat_valid,
   output logic                       o_beat_ready,
   input  logic [BEAT_WIDTH-1:0]      i_beat_data,
   input  logic                       i_beat_last,
   output logic                       o_refill_done,
   output logic                       o_refill_err
`ifdef RISCV_DCACHE_BYTE_PARITY_EN
   ,
   output logic                       o_parity_err
`endif
);

   localparam int SETS       = 2 ** INDEX_WIDTH;
   localparam int OFFSET     = $clog2(LINE_BYTES);
   localparam int WORDS      = LINE_BYTES / 8;
   localparam int WORD_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int BEATS      = (LINE_BYTES * 8) / BEAT_WIDTH;
   localparam int BEAT_WORDS = BEAT_WIDTH / 64;
   localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int MEM_DEPTH  = NUM_WAYS * SETS * WORDS;
   localparam int MEM_AW     = $clog2(MEM_DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_REFILL = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------------

   // Flat word address: way-major, then set, then word within the line.
   function automatic logic [MEM_AW-1:0] word_addr(
      input logic [WAY_W-1:0]       way,
      input logic [INDEX_WIDTH-1:0] idx,
      input logic [31:0]            word
   );
      logic [31:0] a;
      a = ((32'(way) % 32'(NUM_WAYS)) * 32'(SETS) + 32'(idx)) * 32'(WORDS) + word;
      return a[MEM_AW-1:0];
   endfunction

   // Byte-enable pattern of an access size, before shifting to its offset.
   function automatic logic [7:0] size_bytes(input logic [1:0] size);
      logic [7:0] m;
      case (size)
         2'b00:   m = 8'h01;
         2'b01:   m = 8'h03;
         2'b10:   m = 8'h0F;
         2'b11:   m = 8'hFF;
         default: m = 8'h00;
      endcase
      return m;
   endfunction

   // Natural alignment check.
   function automatic logic is_misaligned(
      input logic [1:0] size,
      input logic [2:0] off
   );
      logic m;
      case (size)
         2'b00:   m = 1'b0;
         2'b01:   m = off[0];
         2'b10:   m = |off[1:0];
         2'b11:   m = |off[2:0];
         default: m = 1'b0;
      endcase
      return m;
   endfunction

   // Expand a byte mask into a bit mask.
   function automatic logic [63:0] bit_mask(input logic [7:0] bytes);
      logic [63:0] m;
      for (int b = 0; b < 8; b++) begin
         m[b*8 +: 8] = {8{bytes[b]}};
      end
      return m;
   endfunction

   // Even parity per byte: stored bit makes each byte+bit have an even
   // number of ones.
   function automatic logic [7:0] byte_parity(input logic [63:0] w);
      logic [7:0] p;
      for (int b = 0; b < 8; b++) begin
         p[b] = ^w[b*8 +: 8];
      end
      return p;
   endfunction

   // Non-zero when any enabled byte disagrees with its stored parity bit.
   function automatic logic parity_fail(
      input logic [63:0] w,
      input logic [7:0]  par,
      input logic [7:0]  bytes
   );
      return |((byte_parity(w) ^ par) & bytes);
   endfunction

   // ------------------------------------------------------------------------
   // Storage (contents are not reset)
   // ------------------------------------------------------------------------
   logic [63:0] mem_r [MEM_DEPTH];
`ifdef RISCV_DCACHE_BYTE_PARITY_EN
   logic [7:0]  par_r [MEM_DEPTH];
`endif

   // ------------------------------------------------------------------------
   // Control state
   // ------------------------------------------------------------------------
   state_t                 state_r;
   state_t                 state_nx_s;
   logic [CNT_W-1:0]       beat_cnt_r;
   logic [INDEX_WIDTH-1:0] fill_idx_r;
   logic [WAY_W-1:0]       fill_way_r;
   logic                   req_ready_s;
   logic                   beat_ready_s;

   // ------------------------------------------------------------------------
   // Core-path decode
   // ------------------------------------------------------------------------
   logic [2:0]             byte_off_s;
   logic [INDEX_WIDTH-1:0] req_idx_s;
   logic [WORD_W-1:0]      req_word_s;
   logic                   req_acc_s;
   logic                   mis_s;
   logic [7:0]             be_s;
   logic [63:0]            src_s;
   logic [63:0]            wdata_s;
   logic                   core_we_s;
   logic [MEM_AW-1:0]      core_addr_s;
   logic [63:0]            rd_word_s;
   logic [63:0]            rd_data_s;

   // ------------------------------------------------------------------------
   // Refill-path decode
   // ------------------------------------------------------------------------
   logic                   beat_acc_s;
   logic                   last_cnt_s;
   logic [MEM_AW-1:0]      beat_base_s;

   // ------------------------------------------------------------------------
   // Registered outputs
   // ------------------------------------------------------------------------
   logic                   rdata_valid_r;
   logic [63:0]            rdata_r;
   logic                   misaligned_r;
   logic                   refill_done_r;
   logic                   refill_err_r;

   // Upper address bits select nothing inside the data array.
   logic unused_addr_s;
   assign unused_addr_s = ^i_req_addr[ADDR_WIDTH-1:OFFSET+INDEX_WIDTH];

   assign byte_off_s = i_req_addr[2:0];
   assign req_idx_s  = i_req_addr[OFFSET+INDEX_WIDTH-1:OFFSET];
   assign req_word_s = WORD_W'(i_req_addr[OFFSET-1:0] >> 3);

   // FSM state register; reset aborts any fill in progress.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next state and port readiness.
   always_comb begin
      state_nx_s   = state_r;
      req_ready_s  = 1'b0;
      beat_ready_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            req_ready_s = 1'b1;
            if (i_refill_start) begin
               state_nx_s = ST_REFILL;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_REFILL: begin
            beat_ready_s = 1'b1;
            if (i_beat_valid && last_cnt_s) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_REFILL;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   assign o_req_ready  = req_ready_s;
   assign o_beat_ready = beat_ready_s;

   // Core access decode: alignment, byte enables, write data lane placement,
   // read extraction.
   always_comb begin
      req_acc_s   = i_req_valid & req_ready_s;
      mis_s       = is_misaligned(i_req_size, byte_off_s);
      be_s        = size_bytes(i_req_size) << byte_off_s;
      // The AMO result only replaces store data for word/dword accesses.
      if (i_amo_wr && i_req_size[1]) begin
         src_s = i_amo_result;
      end else begin
         src_s = i_req_wdata;
      end
      wdata_s     = src_s << {byte_off_s, 3'b000};
      core_we_s   = req_acc_s & i_req_we & ~mis_s;
      core_addr_s = word_addr(i_req_way, req_idx_s, 32'(req_word_s));
      rd_word_s   = mem_r[core_addr_s];
      rd_data_s   = (rd_word_s >> {byte_off_s, 3'b000}) &
                    bit_mask(size_bytes(i_req_size));
   end

   // Refill beat decode.
   // The counter alone decides where a beat lands and when the line is
   // complete.
   always_comb begin
      beat_acc_s  = i_beat_valid & beat_ready_s;
      last_cnt_s  = (beat_cnt_r == CNT_W'(BEATS - 1));
      beat_base_s = word_addr(fill_way_r, fill_idx_r,
                              32'(beat_cnt_r) * 32'(BEAT_WORDS));
   end

   // Refill target latch and beat counter.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         beat_cnt_r <= {CNT_W{1'b0}};
         fill_idx_r <= {INDEX_WIDTH{1'b0}};
         fill_way_r <= {WAY_W{1'b0}};
      end else begin
         if ((state_r == ST_IDLE) && i_refill_start) begin
            fill_idx_r <= i_refill_index;
            fill_way_r <= i_refill_way;
         end
         if (beat_acc_s) begin
            if (last_cnt_s) begin
               beat_cnt_r <= {CNT_W{1'b0}};
            end else begin
               beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            end
         end
      end
   end

   // Array write port.
   // Core writes happen only in IDLE and beats only in REFILL, so the two
   // never collide.
   always_ff @(posedge i_clk) begin
      if (core_we_s) begin
         for (int b = 0; b < 8; b++) begin
            if (be_s[b]) begin
               mem_r[core_addr_s][b*8 +: 8] <= wdata_s[b*8 +: 8];
            end
         end
      end else if (beat_acc_s) begin
         for (int j = 0; j < BEAT_WORDS; j++) begin
            mem_r[beat_base_s + MEM_AW'(j)] <= i_beat_data[j*64 +: 64];
         end
      end
   end

`ifdef RISCV_DCACHE_BYTE_PARITY_EN
   logic parity_err_r;

   // Parity write port, tracking the data array byte for byte.
   always_ff @(posedge i_clk) begin
      if (core_we_s) begin
         for (int b = 0; b < 8; b++) begin
            if (be_s[b]) begin
               par_r[core_addr_s][b] <= ^wdata_s[b*8 +: 8];
            end
         end
      end else if (beat_acc_s) begin
         for (int j = 0; j < BEAT_WORDS; j++) begin
            par_r[beat_base_s + MEM_AW'(j)] <= byte_parity(i_beat_data[j*64 +: 64]);
         end
      end
   end

   // Parity check of the bytes an aligned read returns.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         parity_err_r <= 1'b0;
      end else begin
         parity_err_r <= req_acc_s & ~i_req_we & ~mis_s &
                         parity_fail(rd_word_s, par_r[core_addr_s], be_s);
      end
   end

   assign o_parity_err = parity_err_r;
`endif

   // Core response and refill status registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rdata_valid_r <= 1'b0;
         rdata_r       <= 64'd0;
         misaligned_r  <= 1'b0;
         refill_done_r <= 1'b0;
         refill_err_r  <= 1'b0;
      end else begin
         rdata_valid_r <= req_acc_s;
         misaligned_r  <= req_acc_s & mis_s;
         if (req_acc_s && !i_req_we && !mis_s) begin
            rdata_r <= rd_data_s;
         end else begin
            rdata_r <= 64'd0;
         end
         refill_done_r <= beat_acc_s & last_cnt_s;
         refill_err_r  <= beat_acc_s & (i_beat_last ^ last_cnt_s);
      end
   end

   assign o_rdata_valid = rdata_valid_r;
   assign o_rdata       = rdata_r;
   assign o_misaligned  = misaligned_r;
   assign o_refill_done = refill_done_r;
   assign o_refill_err  = refill_err_r;

endmodule

// File: tb/tb_riscv_core_dcache_data_array.sv
// ----------------------------------------------------------------------------
// tb_riscv_core_dcache_data_array
//
// Self-checking bench for riscv_core_dcache_data_array (default parameters:
// 2 ways, 128 sets, 32-byte lines, 64-bit beats).
// The reference model is a plain byte array per way/set/line-byte.
// ----------------------------------------------------------------------------
module tb_riscv_core_dcache_data_array;

   localparam int NUM_WAYS   = 2;
   localparam int SETS       = 128;
   localparam int LINE_BYTES = 32;
   localparam int BEATS      = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, amo_wr;
   logic [63:0] req_addr, req_wdata, amo_result;
   logic [0:0]  req_way;
   logic [1:0]  req_size;
   logic        rdata_valid, misaligned;
   logic [63:0] rdata;
   logic        refill_start;
   logic [6:0]  refill_index;
   logic [0:0]  refill_way;
   logic        beat_valid, beat_ready, beat_last;
   logic [63:0] beat_data;
   logic        refill_done, refill_err;

   logic [7:0]  ref_line [NUM_WAYS][SETS][LINE_BYTES];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   riscv_core_dcache_data_array dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_we       (req_we),
      .i_req_addr     (req_addr),
      .i_req_way      (req_way),
      .i_req_size     (req_size),
      .i_req_wdata    (req_wdata),
      .i_amo_wr       (amo_wr),
      .i_amo_result   (amo_result),
      .o_rdata_valid  (rdata_valid),
      .o_rdata        (rdata),
      .o_misaligned   (misaligned),
      .i_refill_start (refill_start),
      .i_refill_index (refill_index),
      .i_refill_way   (refill_way),
      .i_beat_valid   (beat_valid),
      .o_beat_ready   (beat_ready),
      .i_beat_data    (beat_data),
      .i_beat_last    (beat_last),
      .o_refill_done  (refill_done),
      .o_refill_err   (refill_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] make_addr(input logic [6:0] set, input logic [4:0] off);
      return {32'($urandom()), 20'($urandom()), set, off};
   endfunction

   function automatic logic [63:0] model_read(input int way, input int set, input int off, input int n);
      logic [63:0] v;
      v = 64'd0;
      for (int i = 0; i < n; i++) begin
         v = v | (64'(ref_line[way][set][off + i]) << (8 * i));
      end
      return v;
   endfunction

   // One core access; called and returning 1 time unit after a rising edge.
   task automatic op(input string tag, input logic we, input logic [63:0] addr, input int way,
                     input logic [1:0] size, input logic [63:0] wdata, input logic amo,
                     input logic [63:0] amo_res);
      int          off, set, n;
      logic        mis;
      logic [63:0] exp, src;
      off = int'(addr[4:0]);
      set = int'(addr[11:5]);
      n   = 1 << size;
      mis = (off % n) != 0;
      exp = (!we && !mis) ? model_read(way, set, off, n) : 64'd0;
      src = (amo && n >= 4) ? amo_res : wdata;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_way = 1'(way);
      req_size = size; req_wdata = wdata; amo_wr = amo; amo_result = amo_res;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0; amo_wr = 1'b0;
      check({tag, ".valid"}, 64'(rdata_valid), 64'd1);
      check({tag, ".mis"}, 64'(misaligned), 64'(mis));
      check({tag, ".data"}, rdata, exp);
      if (we && !mis) begin
         for (int i = 0; i < n; i++) begin
            ref_line[way][set][off + i] = src[8*i +: 8];
         end
      end
   endtask

   // Line fill. bad_last flips i_beat_last on that beat (-1: none).
   // abort_at resets before that beat (-1: none).
   // rd_en issues a dword read in the refill_start cycle.
   task automatic refill(input string tag, input int set, input int way, input logic [63:0] beats [4],
                         input int bad_last, input int abort_at, input logic rd_en,
                         input logic [63:0] rd_addr, input int rd_way);
      logic [63:0] rd_exp;
      rd_exp = model_read(rd_way, int'(rd_addr[11:5]), int'(rd_addr[4:0]), 8);
      refill_start = 1'b1; refill_index = 7'(set); refill_way = 1'(way);
      if (rd_en) begin
         req_valid = 1'b1; req_we = 1'b0; req_addr = rd_addr; req_way = 1'(rd_way); req_size = 2'b11;
      end
      @(posedge clk); #1;
      refill_start = 1'b0; req_valid = 1'b0;
      if (rd_en) begin
         check({tag, ".rd_valid"}, 64'(rdata_valid), 64'd1);
         check({tag, ".rd_data"}, rdata, rd_exp);
      end
      check({tag, ".req_ready_lo"}, 64'(req_ready), 64'd0);
      check({tag, ".beat_ready"}, 64'(beat_ready), 64'd1);
      for (int k = 0; k < BEATS; k++) begin
         if (abort_at == k) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            check({tag, ".abort_ready"}, 64'(req_ready), 64'd1);
            check({tag, ".abort_bready"}, 64'(beat_ready), 64'd0);
            for (int c = 0; c < 4; c++) begin
               @(posedge clk); #1;
               check({tag, ".abort_nodone"}, 64'(refill_done), 64'd0);
            end
            return;
         end
         repeat ($urandom_range(0, 1)) begin
            beat_valid = 1'b0;
            @(posedge clk); #1;
            check({tag, ".gap_nodone"}, 64'(refill_done), 64'd0);
         end
         beat_valid = 1'b1;
         beat_data  = beats[k];
         beat_last  = (k == BEATS - 1) ^ (k == bad_last);
         @(posedge clk); #1;
         beat_valid = 1'b0; beat_last = 1'b0;
         check($sformatf("%s.done%0d", tag, k), 64'(refill_done), 64'(k == BEATS - 1));
         check($sformatf("%s.err%0d", tag, k), 64'(refill_err), 64'(k == bad_last));
         for (int i = 0; i < 8; i++) begin
            ref_line[way][set][k*8 + i] = beats[k][8*i +: 8];
         end
      end
      check({tag, ".ready_back"}, 64'(req_ready), 64'd1);
   endtask

   function automatic void rand_beats(output logic [63:0] b [4]);
      for (int k = 0; k < 4; k++) begin
         b[k] = {$urandom(), $urandom()};
      end
   endfunction

   initial begin
      logic [63:0] bts [4];
      logic [1:0]  sz;
      int          s, w, off, n;

      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 64'd0; req_way = 1'b0;
      req_size = 2'b00; req_wdata = 64'd0; amo_wr = 1'b0; amo_result = 64'd0;
      refill_start = 1'b0; refill_index = 7'd0; refill_way = 1'b0;
      beat_valid = 1'b0; beat_data = 64'd0; beat_last = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.rdata_valid", 64'(rdata_valid), 64'd0);
      check("rst.rdata", rdata, 64'd0);
      check("rst.misaligned", 64'(misaligned), 64'd0);
      check("rst.done", 64'(refill_done), 64'd0);
      check("rst.err", 64'(refill_err), 64'd0);
      check("rst.req_ready", 64'(req_ready), 64'd1);
      check("rst.beat_ready", 64'(beat_ready), 64'd0);
      rst_n = 1'b1;

      // Populate every line so no read ever sees uninitialised storage.
      for (int si = 0; si < SETS; si++) begin
         for (int wi = 0; wi < NUM_WAYS; wi++) begin
            rand_beats(bts);
            refill("fill", si, wi, bts, -1, -1, 1'b0, 64'd0, 0);
         end
      end

      // Known line in set 5 way 1.
      bts[0] = 64'h1111111111111111; bts[1] = 64'h2222222222222222;
      bts[2] = 64'h3333333333333333; bts[3] = 64'h4444444444444444;
      refill("kn", 5, 1, bts, -1, -1, 1'b0, 64'd0, 0);
      op("kn.rd0", 1'b0, 64'h0A0, 1, 2'b11, 64'd0, 1'b0, 64'd0);
      check("kn.rd0_abs", rdata, 64'h1111111111111111);
      op("kn.rd1", 1'b0, 64'h0A8, 1, 2'b11, 64'd0, 1'b0, 64'd0);
      op("kn.rd2", 1'b0, 64'h0B0, 1, 2'b11, 64'd0, 1'b0, 64'd0);
      op("kn.rd3", 1'b0, 64'h0B8, 1, 2'b11, 64'd0, 1'b0, 64'd0);
      check("kn.rd3_abs", rdata, 64'h4444444444444444);

      // Byte store then immediate dword read of the same word.
      op("bw.wr", 1'b1, 64'h0A3, 1, 2'b00, 64'hAB, 1'b0, 64'd0);
      op("bw.rd", 1'b0, 64'h0A0, 1, 2'b11, 64'd0, 1'b0, 64'd0);
      check("bw.rd_abs", rdata, 64'h11111111AB111111);
      op("bw.other_way", 1'b0, 64'h0A0, 0, 2'b11, 64'd0, 1'b0, 64'd0);

      // Misaligned half read, then aligned word read.
      op("mis.half", 1'b0, 64'h0A1, 1, 2'b01, 64'd0, 1'b0, 64'd0);
      op("mis.wr", 1'b1, 64'h0A2, 1, 2'b10, 64'hFFFF_FFFF, 1'b0, 64'd0);
      op("al.word", 1'b0, 64'h0A4, 1, 2'b10, 64'd0, 1'b0, 64'd0);
      check("al.word_abs", rdata, 64'h11111111);
      op("mis.chk", 1'b0, 64'h0A0, 1, 2'b11, 64'd0, 1'b0, 64'd0);

      // AMO word write and AMO flag on a byte store.
      op("amo.wr", 1'b1, 64'h0A8, 1, 2'b10, 64'h5, 1'b1, 64'hDEADBEEF);
      op("amo.rd", 1'b0, 64'h0A8, 1, 2'b10, 64'd0, 1'b0, 64'd0);
      check("amo.rd_abs", rdata, 64'hDEADBEEF);
      op("amob.wr", 1'b1, 64'h0A8, 1, 2'b00, 64'h5, 1'b1, 64'hDEADBEEF);
      op("amob.rd", 1'b0, 64'h0A8, 1, 2'b00, 64'd0, 1'b0, 64'd0);
      check("amob.rd_abs", rdata, 64'h05);

      // Early last marker on beat 1, missing last on beat 3.
      rand_beats(bts);
      refill("err1", 5, 0, bts, 1, -1, 1'b0, 64'd0, 0);
      op("err1.rd", 1'b0, 64'h0B8, 0, 2'b11, 64'd0, 1'b0, 64'd0);
      rand_beats(bts);
      refill("err3", 6, 0, bts, 3, -1, 1'b0, 64'd0, 0);

      // Reset after beat 2, then refill the now-undefined line.
      rand_beats(bts);
      refill("abort", 9, 0, bts, -1, 3, 1'b0, 64'd0, 0);
      rand_beats(bts);
      refill("refill9", 9, 0, bts, -1, -1, 1'b0, 64'd0, 0);

      // Refill start with a same-cycle read.
      rand_beats(bts);
      refill("sc", 12, 1, bts, -1, -1, 1'b1, make_addr(7'd5, 5'd16), 1);
      op("sc.rd", 1'b0, make_addr(7'd12, 5'd8), 1, 2'b11, 64'd0, 1'b0, 64'd0);

      // Random mix of accesses and occasional fills.
      for (int it = 0; it < 400; it++) begin
         s  = $urandom_range(0, SETS - 1);
         w  = $urandom_range(0, NUM_WAYS - 1);
         if ($urandom_range(0, 19) == 0) begin
            rand_beats(bts);
            refill("rnd.fill", s, w, bts, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1,
                   -1, 1'($urandom_range(0, 1)), make_addr(7'($urandom_range(0, SETS - 1)), 5'd0),
                   $urandom_range(0, 1));
         end else begin
            sz  = 2'($urandom_range(0, 3));
            n   = 1 << sz;
            off = $urandom_range(0, LINE_BYTES - 1);
            if ($urandom_range(0, 3) != 0) begin
               off = off & ~(n - 1);
            end
            op("rnd", 1'($urandom_range(0, 1)), make_addr(7'(s), 5'(off)), w, sz,
               {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), {$urandom(), $urandom()});
         end
      end

      @(posedge clk); #1;
      check("idle.valid_lo", 64'(rdata_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
